player_shot_controller: RTL and testbench

Owns the player's single laser shot: converts the fire button into a launched shot, moves it up the playfield, retires it on an alien hit, at the top border or when the game ends, and draws it. It sits directly upstream of the alien controller, which consumes `shot_active`/`shot_x`/`shot_y` and returns the `shot_hit` pulse. It also feeds the VGA pixel mux alongside `alien_on`.

---
 rtl/space_inv_pkg.sv | 14 +
 rtl/fire_sync_edge.sv | 32 +++
 rtl/player_shot_controller.sv | 176 +++++++++++++++++
 tb/tb_player_shot_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/space_inv_pkg.sv
// rtl/space_inv_pkg.sv - shared widths and shot FSM state encoding
package space_inv_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    FLYING   = 2'd2,
    COOLDOWN = 2'd3
  } shot_state_e;

endpackage

// File: rtl/fire_sync_edge.sv
// rtl/fire_sync_edge.sv - fire button 2-FF synchronizer and rising-edge pulse
module fire_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic hold_i,
  input  logic fire_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;

  // Synchronizer and history always sample so an edge completing under hold is consumed, not deferred
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= fire_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q & ~hold_i;
    end
  end

  assign edge_o = pulse_q;

endmodule

// File: rtl/player_shot_controller.sv
// rtl/player_shot_controller.sv - player laser shot FSM, mover and draw path; SHOT_COOLDOWN_EN enables tick-timed cooldown
module player_shot_controller
  import space_inv_pkg::*;
#(
  parameter int          SHOT_W         = 2,
  parameter int          SHOT_H         = 8,
  parameter int          SHOT_VELOCITY  = 4,
  parameter int          MOVE_INTERVAL  = 200000,
  parameter int          Y_TOP          = 16,
  parameter int          COOLDOWN_TICKS = 8,
  parameter logic [11:0] SHOT_RGB       = 12'hFF0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pause,
  input  logic                 freeze,
  input  logic                 fire,
  input  logic [COORD_W-1:0]   player_x,
  input  logic [COORD_W-1:0]   player_y,
  input  logic                 shot_hit,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  output logic                 shot_active,
  output logic [COORD_W-1:0]   shot_x,
  output logic [COORD_W-1:0]   shot_y,
  output logic                 shot_on,
  output logic [RGB_W-1:0]     shot_rgb,
  output logic [15:0]          shots_fired
);

  localparam int TICK_W = $clog2(MOVE_INTERVAL + 1);
  localparam logic [TICK_W-1:0]  TICK_MAX   = TICK_W'(MOVE_INTERVAL);
  localparam logic [COORD_W-1:0] HALF_W     = COORD_W'(SHOT_W / 2);
  localparam logic [COORD_W-1:0] SH         = COORD_W'(SHOT_H);
  localparam logic [COORD_W-1:0] VEL        = COORD_W'(SHOT_VELOCITY);
  localparam logic [COORD_W-1:0] YTOP       = COORD_W'(Y_TOP);
  // Lowest player_y whose shot tip still lands on or below the top border
  localparam logic [COORD_W-1:0] LAUNCH_MIN = COORD_W'(Y_TOP + SHOT_H);
  // A shot above this line would cross the border on its next move
  localparam logic [COORD_W-1:0] RETIRE_Y   = COORD_W'(Y_TOP + SHOT_VELOCITY);

  shot_state_e          state_q, state_d;
  logic [COORD_W-1:0]   shot_x_q, shot_x_d;
  logic [COORD_W-1:0]   shot_y_q, shot_y_d;
  logic [15:0]          fired_q, fired_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic                 fire_edge;

  logic                 hit_q;
  logic                 shot_on_q;
  logic [RGB_W-1:0]     shot_rgb_q;
  logic [COORD_W:0]     x_end;
  logic [COORD_W:0]     y_end;

`ifdef SHOT_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CD_W-1:0] CD_MAX = CD_W'(COOLDOWN_TICKS - 1);
  logic [CD_W-1:0] cool_cnt_q, cool_cnt_d;
`else
  logic unused_cooldown_cfg;
  assign unused_cooldown_cfg = ^COOLDOWN_TICKS;
`endif

  fire_sync_edge u_fire_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .hold_i (pause),
    .fire_i (fire),
    .edge_o (fire_edge)
  );

  assign tick = (tick_cnt_q == TICK_MAX);

  // Control state register; asynchronous reset kills any shot in flight immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shot_x_q   <= '0;
      shot_y_q   <= '0;
      fired_q    <= '0;
      tick_cnt_q <= '0;
`ifdef SHOT_COOLDOWN_EN
      cool_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shot_x_q   <= shot_x_d;
      shot_y_q   <= shot_y_d;
      fired_q    <= fired_d;
      tick_cnt_q <= tick_cnt_d;
`ifdef SHOT_COOLDOWN_EN
      cool_cnt_q <= cool_cnt_d;
`endif
    end
  end

  // Next-state: launch, move, retire; everything holds while paused
  always_comb begin
    state_d    = state_q;
    shot_x_d   = shot_x_q;
    shot_y_d   = shot_y_q;
    fired_d    = fired_q;
    tick_cnt_d = tick_cnt_q;
`ifdef SHOT_COOLDOWN_EN
    cool_cnt_d = cool_cnt_q;
`endif
    if (!pause) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      case (state_q)
        IDLE: begin
          if (fire_edge && !freeze) begin
            state_d  = LAUNCH;
            shot_x_d = player_x - HALF_W;
            shot_y_d = (player_y >= LAUNCH_MIN) ? (player_y - SH) : YTOP;
            fired_d  = fired_q + 16'd1;
          end
        end
        LAUNCH: state_d = FLYING;
        FLYING: begin
          // A hit beats a coincident move tick, so the position stays where the hit occurred
          if (shot_hit || freeze) begin
            state_d = COOLDOWN;
          end else if (tick) begin
            if (shot_y_q < RETIRE_Y) begin
              state_d = COOLDOWN;
            end else begin
              shot_y_d = shot_y_q - VEL;
            end
          end
        end
        COOLDOWN: begin
`ifdef SHOT_COOLDOWN_EN
          if (tick) begin
            if (cool_cnt_q == CD_MAX) begin
              cool_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              cool_cnt_d = cool_cnt_q + CD_W'(1);
            end
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign x_end = {1'b0, shot_x_q} + (COORD_W + 1)'(SHOT_W);
  assign y_end = {1'b0, shot_y_q} + (COORD_W + 1)'(SHOT_H);

  // Two-stage draw pipeline to line up with alien_on; keeps running during pause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q      <= 1'b0;
      shot_on_q  <= 1'b0;
      shot_rgb_q <= '0;
    end else begin
      hit_q      <= shot_active
                    && (pixel_x >= shot_x_q) && ({1'b0, pixel_x} < x_end)
                    && (pixel_y >= shot_y_q) && ({1'b0, pixel_y} < y_end);
      shot_on_q  <= hit_q;
      shot_rgb_q <= hit_q ? SHOT_RGB : '0;
    end
  end

  assign shot_active = (state_q == FLYING);
  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;
  assign shot_on     = shot_on_q;
  assign shot_rgb    = shot_rgb_q;
  assign shots_fired = fired_q;

endmodule

// File: tb/tb_player_shot_controller.sv
// tb/tb_player_shot_controller.sv - directed self-checking bench for player_shot_controller
module tb_player_shot_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic        freeze = 1'b0;
  logic        fire = 1'b0;
  logic [10:0] player_x = '0;
  logic [10:0] player_y = '0;
  logic        shot_hit = 1'b0;
  logic [10:0] pixel_x = '0;
  logic [10:0] pixel_y = '0;
  logic        shot_active;
  logic [10:0] shot_x;
  logic [10:0] shot_y;
  logic        shot_on;
  logic [11:0] shot_rgb;
  logic [15:0] shots_fired;

  int n_asserts = 0;
  int n_fail    = 0;
  int phase     = 0;

  player_shot_controller #(
    .MOVE_INTERVAL  (4),
    .COOLDOWN_TICKS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pause       (pause),
    .freeze      (freeze),
    .fire        (fire),
    .player_x    (player_x),
    .player_y    (player_y),
    .shot_hit    (shot_hit),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .shot_active (shot_active),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .shot_on     (shot_on),
    .shot_rgb    (shot_rgb),
    .shots_fired (shots_fired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; phase tracks the move-tick counter (period 5, frozen by pause)
  task automatic step();
    logic p;
    p = pause;
    @(posedge clk);
    #1;
    if (!p) phase = (phase == 4) ? 0 : phase + 1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the edge that consumed a move tick
  task automatic step_to_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (phase != 0 && n < 10);
  endtask

  initial begin
    steps(2);
    reset = 1'b0;
    phase = 0;

    check("rst_active", shot_active, 0);
    check("rst_x", shot_x, 0);
    check("rst_y", shot_y, 0);
    check("rst_on", shot_on, 0);
    check("rst_rgb", shot_rgb, 0);
    check("rst_fired", shots_fired, 0);

    player_x = 11'd320; player_y = 11'd440;
    fire = 1'b1;
    steps(4);
    check("launch_lat4", shot_active, 0);
    step();
    check("launch_lat5", shot_active, 1);
    check("launch_x", shot_x, 319);
    check("launch_y", shot_y, 432);
    check("launch_fired", shots_fired, 1);
    fire = 1'b0;

    pixel_x = 11'd320; pixel_y = 11'd434;
    step();
    check("draw_s1", shot_on, 0);
    step();
    check("draw_on", shot_on, 1);
    check("draw_rgb", shot_rgb, 12'hFF0);
    pixel_x = 11'd321;
    steps(2);
    check("draw_off", shot_on, 0);
    check("draw_off_rgb", shot_rgb, 0);

    step_to_tick();
    check("fly_y1", shot_y, 428);
    steps(4);
    check("fly_hold", shot_y, 428);
    step();
    check("fly_y2", shot_y, 424);

    fire = 1'b1;
    steps(3);
    fire = 1'b0;
    step();
    check("fly_refire_active", shot_active, 1);
    check("fly_refire_fired", shots_fired, 1);
    check("fly_refire_y", shot_y, 424);
    step();
    check("fly_y3", shot_y, 420);

    pause = 1'b1;
    fire = 1'b1;
    pixel_x = 11'd319; pixel_y = 11'd420;
    steps(10);
    check("pause_y", shot_y, 420);
    check("pause_active", shot_active, 1);
    check("pause_fired", shots_fired, 1);
    check("pause_draw", shot_on, 1);
    fire = 1'b0;
    steps(4);
    pause = 1'b0;
    pixel_x = 11'd0; pixel_y = 11'd0;
    steps(4);
    check("unpause_y", shot_y, 420);
    check("unpause_fired", shots_fired, 1);
    step();
    check("unpause_move", shot_y, 416);

    freeze = 1'b1;
    step();
    check("freeze_retire", shot_active, 0);
    fire = 1'b1;
    steps(8);
    check("freeze_nofire", shot_active, 0);
    check("freeze_fired", shots_fired, 1);
    check("freeze_y", shot_y, 416);
    fire = 1'b0; freeze = 1'b0;
    steps(3);

    player_x = 11'd100; player_y = 11'd27;
    fire = 1'b1;
    steps(5);
    check("top_active", shot_active, 1);
    check("top_y", shot_y, 19);
    check("top_fired", shots_fired, 2);
    fire = 1'b0;
    step_to_tick();
    check("top_retire", shot_active, 0);
    check("top_y_hold", shot_y, 19);
    steps(2);

    player_y = 11'd28;
    fire = 1'b1;
    steps(5);
    check("b20_y", shot_y, 20);
    fire = 1'b0;
    step_to_tick();
    check("b20_move", shot_y, 16);
    check("b20_active", shot_active, 1);
    step_to_tick();
    check("b16_retire", shot_active, 0);
    steps(2);

    player_y = 11'd3;
    fire = 1'b1;
    steps(5);
    check("clamp_y", shot_y, 16);
    check("clamp_x", shot_x, 99);
    check("clamp_fired", shots_fired, 4);
    fire = 1'b0;
    step_to_tick();
    check("clamp_retire", shot_active, 0);
    steps(2);

    while (phase != 4) step();
    player_x = 11'd50; player_y = 11'd208;
    fire = 1'b1;
    steps(5);
    check("hit_pre_active", shot_active, 1);
    check("hit_pre_y", shot_y, 200);
    check("hit_pre_x", shot_x, 49);
    check("hit_pre_fired", shots_fired, 5);
    shot_hit = 1'b1;
    fire = 1'b0;
    step();
    shot_hit = 1'b0;
    check("hit_retire", shot_active, 0);
    check("hit_y", shot_y, 200);

`ifdef SHOT_COOLDOWN_EN
    fire = 1'b1;
    steps(5);
    check("cool_ignored", shot_active, 0);
    check("cool_fired", shots_fired, 5);
    fire = 1'b0;
    steps(10);
`endif
    fire = 1'b1;
    steps(4);
    check("refire_lat4", shot_active, 0);
    step();
    check("refire_active", shot_active, 1);
    check("refire_fired", shots_fired, 6);
    fire = 1'b0;

    #3;
    reset = 1'b1;
    #1;
    check("areset_active", shot_active, 0);
    check("areset_fired", shots_fired, 0);
    check("areset_y", shot_y, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
